// File: rtl/eddy_acq_pkg.sv
// eddy_acq_pkg: shared FSM encoding and counter widths for the eddy sensor
// acquisition block. Counter widths cover the largest legal CNV_CYCLES and
// SCLK_DIV (255) and DATA_WIDTH (32).
package eddy_acq_pkg;

    localparam int CYC_CNT_W = 8;
    localparam int BIT_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } acq_state_e;

endpackage

// File: rtl/eddy_acq_sclk_gen.sv
// eddy_acq_sclk_gen: serial clock generator for the ADC read phase.
// After 'start' it produces sclk low for div cycles then high for div cycles,
// repeating until 'stop'. 'sample' marks the cycle whose closing edge drives
// sclk 0->1; 'bit_end' marks the cycle whose closing edge ends a high phase.
module eddy_acq_sclk_gen
    import eddy_acq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CYC_CNT_W-1:0] div,
    output logic                 sclk,
    output logic                 sample,
    output logic                 bit_end
);

    logic [CYC_CNT_W-1:0] cnt_q, cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 run_q, run_d;
    logic                 phase_end;

    assign phase_end = run_q && (cnt_q == div - 8'd1);
    assign sample    = phase_end && !sclk_q;
    assign bit_end   = phase_end && sclk_q;
    assign sclk      = sclk_q;

    // Phase counter and sclk toggle; start/stop force a clean low phase.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        run_d  = run_q;
        if (start) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (stop) begin
            run_d  = 1'b0;
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (run_q) begin
            if (phase_end) begin
                cnt_d  = '0;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State registers; reset drops sclk immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/eddy_sensor_acq.sv
// eddy_sensor_acq: trigger/enable/done responder that runs one CNV pulse plus
// serial ADC read per accepted trigger and presents the sample with a level
// 'done'. Optional build macro: EDDY_ACQ_OVERRUN_EN enables the sticky
// 'overrun' flag (trigger seen while busy); otherwise 'overrun' is tied low.
module eddy_sensor_acq
    import eddy_acq_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int CNV_CYCLES = 4,
    parameter int SCLK_DIV   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic                  enable,
    input  logic                  miso,
    output logic                  cnv,
    output logic                  sclk,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  done,
    output logic                  busy,
    output logic                  overrun
);

    acq_state_e            state_q, state_d;
    logic [CYC_CNT_W-1:0]  cyc_q, cyc_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  cnv_q, cnv_d;
    logic                  busy_q, busy_d;
    logic                  gen_start, gen_stop;
    logic                  gen_sample, gen_bit_end;

    eddy_acq_sclk_gen u_sclk_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (gen_start),
        .stop    (gen_stop),
        .div     (CYC_CNT_W'(SCLK_DIV)),
        .sclk    (sclk),
        .sample  (gen_sample),
        .bit_end (gen_bit_end)
    );

    // Acquisition FSM: accept trigger, time CNV, count bits, capture sample.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = done_q;
        cnv_d     = cnv_q;
        busy_d    = busy_q;
        gen_start = 1'b0;
        gen_stop  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (trigger) begin
                    done_d = 1'b0;
                    if (enable) begin
                        state_d = ST_CONVERT;
                        cnv_d   = 1'b1;
                        busy_d  = 1'b1;
                        cyc_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CONVERT: begin
                if (cyc_q == CYC_CNT_W'(CNV_CYCLES - 1)) begin
                    cnv_d     = 1'b0;
                    bit_d     = '0;
                    gen_start = 1'b1;
                    state_d   = ST_SHIFT;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (gen_sample) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], miso};
                end
                if (gen_bit_end) begin
                    if (bit_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        gen_stop = 1'b1;
                        data_d   = shift_q;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers; reset clears outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            cnv_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            cnv_q   <= cnv_d;
            busy_q  <= busy_d;
        end
    end

`ifdef EDDY_ACQ_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky overrun: set by a trigger while busy, cleared by a disabled trigger.
    always_comb begin
        overrun_d = overrun_q;
        if (trigger && busy_q) begin
            overrun_d = 1'b1;
        end else if (trigger && !enable) begin
            overrun_d = 1'b0;
        end
    end

    // Overrun flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign cnv  = cnv_q;
    assign data = data_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_eddy_sensor_acq.sv
// tb_eddy_sensor_acq: directed bench for eddy_sensor_acq. Instance A uses the
// default parameters, instance B the minimum (CNV=1, SCLK_DIV=1, width 2).
// Expected waveforms are computed per cycle relative to the trigger cycle T.
module tb_eddy_sensor_acq;

`ifdef EDDY_ACQ_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        trig_a = 1'b0, en_a = 1'b0, miso_a = 1'b0;
    logic        cnv_a, sclk_a, done_a, busy_a, ovr_a;
    logic [17:0] data_a;

    logic        trig_b = 1'b0, en_b = 1'b0, miso_b = 1'b0;
    logic        cnv_b, sclk_b, done_b, busy_b, ovr_b;
    logic [1:0]  data_b;

    int   tests   = 0;
    int   fails   = 0;
    logic ovr_exp = 1'b0;

    eddy_sensor_acq u_dut_a (
        .clk(clk), .rst(rst), .trigger(trig_a), .enable(en_a), .miso(miso_a),
        .cnv(cnv_a), .sclk(sclk_a), .data(data_a), .done(done_a),
        .busy(busy_a), .overrun(ovr_a)
    );

    eddy_sensor_acq #(.DATA_WIDTH(2), .CNV_CYCLES(1), .SCLK_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .trigger(trig_b), .enable(en_b), .miso(miso_b),
        .cnv(cnv_b), .sclk(sclk_b), .data(data_b), .done(done_b),
        .busy(busy_b), .overrun(ovr_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        tests++;
        if ({cnv_a, sclk_a, done_a, busy_a, ovr_a, data_a} !== 23'd0) begin
            fails++;
            $display("FAIL reset_a got=%b exp=0", {cnv_a, sclk_a, done_a, busy_a, ovr_a, data_a});
        end
        tests++;
        if ({cnv_b, sclk_b, done_b, busy_b, ovr_b, data_b} !== 7'd0) begin
            fails++;
            $display("FAIL reset_b got=%b exp=0", {cnv_b, sclk_b, done_b, busy_b, ovr_b, data_b});
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({cnv_a, sclk_a, done_a, busy_a, ovr_a, data_a} !== 23'd0) begin
            fails++;
            $display("FAIL reset_release_a got=%b exp=0", {cnv_a, sclk_a, done_a, busy_a, ovr_a, data_a});
        end
        ovr_exp = 1'b0;
        $display("[TB] reset checked");
    endtask

    // One default-parameter acquisition triggered now (cycle T); optional
    // extra trigger in cycle T+retrig_c. Runs to T+100.
    task automatic test_acq_a(input logic [17:0] pat, input logic [17:0] old, input int retrig_c);
        logic [4:0]  exp_ctl;
        logic [4:0]  act_ctl;
        logic [17:0] exp_data;
        logic        exp_ovr;
        logic        prev_sclk;
        int          idx;
        int          rises;
        rises     = 0;
        prev_sclk = 1'b0;
        exp_ovr   = ovr_exp;
        trig_a    = 1'b1;
        en_a      = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            trig_a = 1'b0;
            idx    = c - 5;
            if (idx >= 0 && idx < 72) miso_a = pat[17 - idx / 4];
            else                      miso_a = 1'b0;
            exp_ovr = OVR_EN && (ovr_exp || (retrig_c > 0 && c > retrig_c));
            exp_ctl = {c <= 4, (idx >= 0 && idx < 72 && (idx % 4) >= 2),
                       c >= 77, c <= 76, exp_ovr};
            act_ctl = {cnv_a, sclk_a, done_a, busy_a, ovr_a};
            tests++;
            if (act_ctl !== exp_ctl) begin
                fails++;
                $display("FAIL acq_a_ctl T+%0d got=%b exp=%b (cnv,sclk,done,busy,ovr)", c, act_ctl, exp_ctl);
            end
            exp_data = (c >= 77) ? pat : old;
            tests++;
            if (data_a !== exp_data) begin
                fails++;
                $display("FAIL acq_a_data T+%0d got=%h exp=%h", c, data_a, exp_data);
            end
            if (sclk_a && !prev_sclk) rises++;
            prev_sclk = sclk_a;
            if (c == retrig_c) trig_a = 1'b1;
        end
        tests++;
        if (rises != 18) begin
            fails++;
            $display("FAIL acq_a_sclk_pulses got=%0d exp=18", rises);
        end
        ovr_exp = exp_ovr;
        $display("[TB] acq_a pat=%h retrig=%0d data=%h", pat, retrig_c, data_a);
    endtask

    // Trigger with enable low: done drops, nothing runs, data held, overrun cleared.
    task automatic test_disabled_a(input logic [17:0] old);
        logic [4:0] act_ctl;
        trig_a = 1'b1;
        en_a   = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            trig_a = 1'b0;
            miso_a = 1'b1;
            act_ctl = {cnv_a, sclk_a, done_a, busy_a, ovr_a};
            tests++;
            if (act_ctl !== 5'd0) begin
                fails++;
                $display("FAIL disabled_ctl T+%0d got=%b exp=00000", c, act_ctl);
            end
            tests++;
            if (data_a !== old) begin
                fails++;
                $display("FAIL disabled_data T+%0d got=%h exp=%h", c, data_a, old);
            end
        end
        en_a    = 1'b1;
        miso_a  = 1'b0;
        ovr_exp = 1'b0;
        $display("[TB] disabled trigger data=%h", data_a);
    endtask

    // Asynchronous reset during CONVERT, then a fresh acquisition.
    task automatic test_rst_mid_a(input logic [17:0] pat);
        trig_a = 1'b1;
        en_a   = 1'b1;
        tick();
        trig_a = 1'b0;
        tick();
        tests++;
        if ({cnv_a, busy_a} !== 2'b11) begin
            fails++;
            $display("FAIL rst_pre_convert got=%b exp=11", {cnv_a, busy_a});
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({cnv_a, sclk_a, done_a, busy_a, ovr_a} !== 5'd0) begin
            fails++;
            $display("FAIL rst_async_ctl got=%b exp=00000", {cnv_a, sclk_a, done_a, busy_a, ovr_a});
        end
        tests++;
        if (data_a !== 18'd0) begin
            fails++;
            $display("FAIL rst_async_data got=%h exp=0", data_a);
        end
        tick();
        rst     = 1'b0;
        ovr_exp = 1'b0;
        $display("[TB] reset during CONVERT");
        test_acq_a(pat, 18'd0, 0);
    endtask

    // Minimum-parameter acquisition: done at T+6, bits sampled at T+2 and T+4 edges.
    task automatic test_small_b(input logic [1:0] pat, input logic [1:0] old);
        logic [4:0] exp_ctl;
        logic [4:0] act_ctl;
        logic [1:0] exp_data;
        logic       prev_sclk;
        int         idx;
        int         rises;
        rises     = 0;
        prev_sclk = 1'b0;
        trig_b    = 1'b1;
        en_b      = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            trig_b = 1'b0;
            idx    = c - 2;
            if (idx >= 0 && idx < 4) miso_b = pat[1 - idx / 2];
            else                     miso_b = ~pat[0];
            exp_ctl = {c == 1, (idx >= 0 && idx < 4 && (idx % 2) == 1),
                       c >= 6, c <= 5, 1'b0};
            act_ctl = {cnv_b, sclk_b, done_b, busy_b, ovr_b};
            tests++;
            if (act_ctl !== exp_ctl) begin
                fails++;
                $display("FAIL small_ctl T+%0d got=%b exp=%b (cnv,sclk,done,busy,ovr)", c, act_ctl, exp_ctl);
            end
            exp_data = (c >= 6) ? pat : old;
            tests++;
            if (data_b !== exp_data) begin
                fails++;
                $display("FAIL small_data T+%0d got=%b exp=%b", c, data_b, exp_data);
            end
            if (sclk_b && !prev_sclk) rises++;
            prev_sclk = sclk_b;
        end
        tests++;
        if (rises != 2) begin
            fails++;
            $display("FAIL small_sclk_pulses got=%0d exp=2", rises);
        end
        $display("[TB] small acq pat=%b data=%b", pat, data_b);
    endtask

    initial begin
        test_reset();
        test_acq_a(18'h2A5A5, 18'h00000, 0);
        test_acq_a(18'h3FFFF, 18'h2A5A5, 0);
        test_disabled_a(18'h3FFFF);
        test_acq_a(18'h15A3C, 18'h3FFFF, 30);
        test_disabled_a(18'h15A3C);
        test_rst_mid_a(18'h0C3F1);
        test_small_b(2'b10, 2'b00);
        test_small_b(2'b01, 2'b10);
        test_small_b(2'b11, 2'b01);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eddy_sensor_acq.md
# eddy_sensor_acq

Sensor-side responder for the timing manager's trigger/enable/done handshake. On each accepted trigger it runs one serial ADC acquisition of an eddy current sensor over a GPIO port: CNV pulse, then SPI-style read. It then raises a level `done` that the timing manager edge-detects to timestamp the sensor and gate the scheduler interrupt. One instance sits per eddy GPIO port, between the timing manager and the port pins.

## Interface
- `DATA_WIDTH`, default 18: bits per sample, MSB first; legal range 2–32.
- `CNV_CYCLES`, default 4: clk cycles that `cnv` is held high; legal range 1–255.
- `SCLK_DIV`, default 2: clk cycles per `sclk` half-period; legal range 1–255.
- `clk  in  1`: system clock; the only clock.
- `rst  in  1`: reset, asynchronous and active-high.
- `trigger  in  1`: one-cycle start pulse from the timing manager.
- `enable  in  1`: per-sensor enable from the timing manager; sampled only in the `trigger` cycle.
- `miso  in  1`: serial data from the sensor ADC; already synchronised at the top level.
- `cnv  out  1`: conversion start to the ADC.
- `sclk  out  1`: serial clock to the ADC; idles low.
- `data  out  DATA_WIDTH`: last completed sample.
- `done  out  1`: level output; high from acquisition completion until the next trigger.
- `busy  out  1`: high in CONVERT and SHIFT.
- `overrun  out  1`: sticky flag; see Configuration.

## Operation
- **Reset values:**
  - FSM is in IDLE.
  - `cnv`, `sclk`, `done`, `busy` and `overrun` are 0.
  - `data` is 0.
  - Shift register and all counters are 0.
- **FSM states:** IDLE, CONVERT, SHIFT, DONE. IDLE and DONE differ only in `done`.
- **IDLE/DONE with `trigger` & `enable`:** go to CONVERT; `done`←0, `cnv`←1, cycle counter←0.
- **IDLE/DONE with `trigger` & !`enable`:** `done`←0 and the FSM goes to IDLE. No conversion runs, so a disabled sensor never shows a stale `done`.
- **CONVERT:**
  - `cnv` stays high for exactly `CNV_CYCLES` cycles.
  - Then `cnv`←0, `sclk`←0, bit counter←0, and the FSM enters SHIFT.
- **SHIFT:**
  - `sclk` is low for `SCLK_DIV` cycles, then high for `SCLK_DIV` cycles, per bit.
  - `miso` is sampled into the shift register LSB on the clk edge that drives `sclk` 0→1.
  - After bit `DATA_WIDTH`'s high phase: `sclk`←0, `data`←shift register, `done`←1, FSM←DONE.
- **Trigger while `busy`:** ignored. The acquisition in progress is not restarted.
- **`enable` falling mid-acquisition:** the acquisition still completes and `done` still rises.
- **`rst` mid-acquisition:** all outputs return to their reset values immediately. `cnv` and `sclk` drop asynchronously.
- **`data`:** updated only on completion and held otherwise.

## Timing
- `trigger` is accepted in cycle T.
- `cnv` is high in cycles T+1 … T+`CNV_CYCLES`.
- SHIFT starts at S = T+1+`CNV_CYCLES`.
- Bit k (0 = MSB) is sampled at S+k·2·`SCLK_DIV`+`SCLK_DIV`.
- `done`=1 and `data` are valid from S+`DATA_WIDTH`·2·`SCLK_DIV`.
  - Defaults: done rises at T+77.
- `done` falls at T+1 for any trigger accepted in IDLE or DONE.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- **`EDDY_ACQ_OVERRUN_EN` defined:**
  - `overrun` sets to 1 on any `trigger` arriving while `busy`.
  - It clears only on `rst` or on a trigger accepted with `enable`=0.
  - It does not affect the acquisition in progress.
- **`EDDY_ACQ_OVERRUN_EN` not defined:** `overrun` is tied to 0 and its logic is absent.

## Structure
- **Package `eddy_acq_pkg`:**
  - FSM state enum.
  - Counter-width constants derived from the parameter maxima (8-bit cycle counter, 6-bit bit counter).
- **Sub-module `eddy_acq_sclk_gen`:**
  - Takes start/stop and `SCLK_DIV`.
  - Produces `sclk`, a one-cycle `sample` strobe at the 0→1 edge, and a `bit_end` strobe.
  - The parent FSM counts bits and owns the shift register.

## Test plan
- **Default parameters, `miso` pattern 0x2A5A5 (MSB first), trigger with `enable`=1 at T:**
  - `cnv` high T+1..T+4.
  - 18 `sclk` pulses.
  - `done`↑ at T+77; `data`=0x2A5A5.
- **Second trigger at T+100 with `miso` held 1:**
  - `done` falls at T+101.
  - `done` rises again at T+177 with `data`=0x3FFFF.
  - `data` reads 0x2A5A5 until T+177.
- **Trigger with `enable`=0 while in DONE:**
  - `done`→0 next cycle.
  - No `cnv`/`sclk` activity.
  - `data` unchanged.
- **Trigger again at T+30 during SHIFT:**
  - The acquisition in progress still completes at T+77.
  - `overrun`=1 with the macro defined; 0 without it.
- **Assert `rst` for 1 cycle during CONVERT, then retrigger:**
  - `cnv`, `done` and `data` read 0 immediately.
  - A fresh acquisition then completes with correct timing.
- **`CNV_CYCLES`=1, `SCLK_DIV`=1, `DATA_WIDTH`=2:**
  - `done`↑ at T+6.
  - Both bits are sampled on the correct edges.
